// File: rtl/seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding and default width.
package seq_mult_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// Operand/product handshake bundle between the execute stage and the multiplier.
interface seq_mult_ctrl_if #(
  parameter int WIDTH = seq_mult_ctrl_pkg::DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

  modport master (
    output in_valid, multiplicand, multiplier, kill, out_ready,
    input  in_ready, out_valid, product_hi, product_lo
  );

  modport slave (
    input  in_valid, multiplicand, multiplier, kill, out_ready,
    output in_ready, out_valid, product_hi, product_lo
  );
endinterface

// File: rtl/seq_mult_ctrl_adder.sv
// Ripple-carry adder; the multiplier reuses one instance every iteration.
module seq_mult_ctrl_adder #(
  parameter int NUM_SIZE = 33
) (
  input  logic [NUM_SIZE-1:0] a,
  input  logic [NUM_SIZE-1:0] b,
  output logic [NUM_SIZE-1:0] sum
);
  logic carry;

  // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < NUM_SIZE; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end
endmodule

// File: rtl/seq_mult_ctrl.sv
// Iterative unsigned WIDTH x WIDTH multiplier, radix-2 shift-add over WIDTH cycles,
// with valid/ready handshakes on operand and product sides.
module seq_mult_ctrl
  import seq_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  seq_mult_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   s;
  logic             accept;
  logic             step;

  // The carry lands in s[WIDTH], so the sum never truncates.
  assign addend = lo[0] ? {1'b0, mcand_q} : '0;

  seq_mult_ctrl_adder #(.NUM_SIZE(WIDTH + 1)) u_add (
    .a   ({1'b0, hi}),
    .b   (addend),
    .sum (s)
  );

  assign accept = (state == IDLE) && bus.in_valid && !bus.kill;
  assign step   = (state == RUN) && !bus.kill;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (bus.kill) state_nxt = IDLE;
               else if (count == LAST) state_nxt = DONE;
      DONE:    if (bus.kill || bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset so the product ports read zero right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      mcand_q <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (accept) begin
      count   <= '0;
      mcand_q <= bus.multiplicand;
      hi      <= '0;
      lo      <= bus.multiplier;
    end else if (step) begin
      count   <= count + 1'b1;
      hi      <= s[WIDTH:1];
      lo      <= {s[0], lo[WIDTH-1:1]};
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.product_hi = hi;
  assign bus.product_lo = lo;
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and randomized bench for seq_mult_ctrl against an arithmetic product model.
module tb_seq_mult_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  seq_mult_ctrl_if #(.WIDTH(W)) bus ();

  seq_mult_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  function automatic logic [63:0] prod();
    return {bus.product_hi, bus.product_lo};
  endfunction

  // Accepts one operation and waits for out_valid; a stray in_valid can be injected at edge 'inject'.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int inject, output int edges);
    int ready_bad = 0;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.in_valid     = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    edges = 0;
    while (!bus.out_valid && edges < 100) begin
      if (bus.in_ready) ready_bad++;
      if (edges == inject) begin
        bus.multiplicand = 32'd7;
        bus.multiplier   = 32'd9;
        bus.in_valid     = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      edges++;
    end
    bus.in_valid = 1'b0;
    check({tag, "_latency"}, 64'(edges), 64'd32);
    check({tag, "_in_ready_low"}, 64'(ready_bad), 64'd0);
    check({tag, "_product"}, prod(), model(a, b));
  endtask

  // Holds out_ready low for 'hold' cycles checking stability, then consumes the product.
  task automatic consume(input string tag, input logic [63:0] exp, input int hold);
    int unstable = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!bus.out_valid || prod() !== exp) unstable++;
    end
    if (hold > 0) check({tag, "_held"}, 64'(unstable), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, "_released"}, {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
  endtask

  initial begin
    int edges;
    int extra;
    logic [31:0] ra, rb;

    bus.in_valid     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    bus.kill         = 1'b0;
    bus.out_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_handshake", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    check("reset_product", prod(), 64'd0);
    rst = 1'b0;
    tick();

    run_op("t1", 32'd3, 32'd5, -1, edges);
    check("t1_lo15", 64'(bus.product_lo), 64'd15);
    consume("t1", model(32'd3, 32'd5), 0);

    run_op("t2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, edges);
    check("t2_const", prod(), 64'hFFFF_FFFE_0000_0001);
    consume("t2", model(32'hFFFF_FFFF, 32'hFFFF_FFFF), 0);

    run_op("t3", 32'h1234_5678, 32'h9ABC_DEF0, -1, edges);
    check("t3_const", prod(), 64'h0B00_EA4E_242D_2080);
    consume("t3", 64'h0B00_EA4E_242D_2080, 10);

    ra = $urandom;
    rb = $urandom;
    run_op("t4", ra, rb, 5, edges);
    consume("t4", model(ra, rb), 0);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.out_valid || !bus.in_ready) extra++;
    end
    check("t4_no_second", 64'(extra), 64'd0);

    // Kill mid-run, then a fresh operation.
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    bus.in_valid     = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (10) tick();
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    check("t5_killed", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    run_op("t5", 32'd2, 32'd4, -1, edges);
    check("t5_lo8", 64'(bus.product_lo), 64'd8);
    consume("t5", 64'd8, 0);

    // Kill in IDLE beats in_valid.
    bus.in_valid = 1'b1;
    bus.kill     = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.kill     = 1'b0;
    check("idle_kill_no_accept", 64'(bus.in_ready), 64'd1);
    tick();
    check("idle_kill_still_idle", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);

    // Kill together with out_ready in DONE.
    run_op("kd", 32'hDEAD_BEEF, 32'h0000_0100, -1, edges);
    bus.kill      = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.kill      = 1'b0;
    bus.out_ready = 1'b0;
    check("kd_dropped", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);

    // Asynchronous reset between edges mid-run.
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    bus.in_valid     = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (20) tick();
    #2 rst = 1'b1;
    #1;
    check("t6_reset_handshake", {62'd0, bus.out_valid, bus.in_ready}, 64'b01);
    check("t6_reset_product", prod(), 64'd0);
    #1 rst = 1'b0;
    tick();
    run_op("t6", 32'd6, 32'd7, -1, edges);
    check("t6_lo42", 64'(bus.product_lo), 64'd42);
    consume("t6", 64'd42, 0);

    // Zero operands and random traffic with random consumer back-pressure.
    run_op("zero_a", 32'd0, $urandom, -1, edges);
    consume("zero_a", 64'd0, 0);
    run_op("zero_b", $urandom, 32'd0, -1, edges);
    consume("zero_b", 64'd0, 0);
    for (int n = 0; n < 8; n++) begin
      ra = $urandom;
      rb = $urandom;
      run_op("rand", ra, rb, -1, edges);
      consume("rand", model(ra, rb), int'($urandom_range(0, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
